// File: rtl/svm_pkg.sv
// Shared constants for the SVM alpha-coefficient RAM and its read sequencer.
package svm_pkg;

  localparam int ALPHA_ADDR_W = 10;
  localparam int ALPHA_DATA_W = 32;
  localparam int NUM_SV       = 629;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry synchronous FIFO holding {data, index, last} entries for the stream output.
module skid_fifo2 #(
  parameter int W = 43
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign dout    = rd_ptr ? mem1 : mem0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clr) begin
      // Stored words are left in place; only the pointers and occupancy matter.
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr) mem1 <= din;
        else        mem0 <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alpha_stream_reader.sv
// Sweeps the alpha RAM from 0 to NUM_SV-1 and streams each word over valid/ready.
//   state | meaning
//   IDLE  | waiting for start; no reads issued
//   RUN   | issuing reads under the two-slot credit limit
//   DRAIN | all reads issued; waiting for the last word to be accepted
module alpha_stream_reader
  import svm_pkg::*;
#(
  parameter int ADDR_W = svm_pkg::ALPHA_ADDR_W,
  parameter int DATA_W = svm_pkg::ALPHA_DATA_W,
  parameter int NUM_SV = svm_pkg::NUM_SV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last
);

  localparam int ENTRY_W = DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(NUM_SV - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SV - 1);

  logic [1:0]         state;
  logic [ADDR_W:0]    issue_cnt;
  logic               in_flight;
  logic [1:0]         fifo_count;
  logic [2:0]         credit_used;
  logic               pop;
  logic               issue;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;

  assign mem_we  = 1'b0;
  assign busy    = (state != IDLE);
  assign m_valid = (fifo_count != 2'd0);
  assign pop     = m_valid && m_ready;

  // A word in flight already owns a slot, so it counts against the limit.
  assign credit_used = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
  assign issue       = (state == RUN) && !abort && (credit_used < 3'd2);

  assign fifo_din = {mem_rdata, mem_addr, (mem_addr == LAST_ADDR)};
  assign m_data   = fifo_dout[ENTRY_W-1 -: DATA_W];
  assign m_index  = fifo_dout[ADDR_W:1];
  assign m_last   = m_valid && fifo_dout[0];

  skid_fifo2 #(
    .W(ENTRY_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (abort),
    .push (in_flight),
    .pop  (pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .count(fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      in_flight <= 1'b0;
      mem_addr  <= '0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      in_flight <= issue;
      if (issue) begin
        mem_addr  <= issue_cnt[ADDR_W-1:0];
        issue_cnt <= issue_cnt + (ADDR_W+1)'(1);
      end
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= RUN;
              issue_cnt <= '0;
            end
          end
          RUN: begin
            if (issue && (issue_cnt == LAST_CNT)) state <= DRAIN;
          end
          DRAIN: begin
            if (pop && m_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alpha_stream_reader.sv
// Directed bench for alpha_stream_reader: cycle vectors for start-up and abort, then full sweeps.
module tb_alpha_stream_reader;
  import svm_pkg::*;

  localparam int AW  = ALPHA_ADDR_W;
  localparam int DW  = ALPHA_DATA_W;
  localparam int NUM = NUM_SV;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_index;
  logic          m_last;

  logic [DW-1:0] ram [1024];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic start;
    logic abort;
    logic rdy;
    logic busy;
    logic valid;
    int   idx;
    int   addr;
  } vec_t;

  vec_t vecs [12];

  alpha_stream_reader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_index  (m_index),
    .m_last   (m_last)
  );

  // RAM whose address register is mem_addr: data for an address is ready by the next edge.
  assign mem_rdata = ram[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // mode 0: ready always; mode 1: ready 1,0,0,1 repeating; mode 2: ready held low 50 cycles.
  task automatic sweep(input int mode, input int restart_idx, input string tag);
    int   e, nxt, bad, stall_bad, we_bad, dones, first_valid, last_e, done_e, busy_at_done;
    logic pv, pready, plast;
    logic [AW-1:0] pidx;
    logic [DW-1:0] pdata;
    bit   pulsed, finished;
    nxt = 0; bad = 0; stall_bad = 0; we_bad = 0; dones = 0;
    first_valid = -1; last_e = -1; done_e = -1; busy_at_done = -1;
    pv = 1'b0; pready = 1'b0; plast = 1'b0; pidx = '0; pdata = '0;
    pulsed = 0; finished = 0;
    start = 1'b1;
    m_ready = 1'b0;
    e = 0;
    while (!finished && e < 4000) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (pv && !pready && !(m_valid && m_index == pidx && m_data == pdata && m_last == plast))
        stall_bad++;
      if (mem_we) we_bad++;
      if (m_valid && first_valid < 0) first_valid = e;
      if (done) begin
        dones++;
        done_e = e;
        busy_at_done = int'(busy);
      end
      if (mode == 2 && e == 49) begin
        chk({tag, "_stall_addr"}, mem_addr, 1);
        chk({tag, "_stall_head"}, m_index, 0);
        chk({tag, "_stall_valid"}, m_valid, 1);
      end
      case (mode)
        1:       m_ready = ((e % 4) == 0) || ((e % 4) == 3);
        2:       m_ready = (e >= 50);
        default: m_ready = 1'b1;
      endcase
      if (restart_idx >= 0 && !pulsed && m_valid && int'(m_index) == restart_idx) begin
        start = 1'b1;
        pulsed = 1;
      end
      if (m_valid && m_ready) begin
        if (int'(m_index) != nxt || m_data != DW'(nxt * 3) || m_last != (nxt == NUM - 1)) bad++;
        if (m_last) last_e = e;
        nxt++;
      end
      pv = m_valid; pready = m_ready; pidx = m_index; pdata = m_data; plast = m_last;
      if (done_e >= 0 && e >= done_e + 2) finished = 1;
      e++;
    end
    start = 1'b0;
    m_ready = 1'b0;
    chk({tag, "_finished"}, finished, 1);
    chk({tag, "_count"}, nxt, NUM);
    chk({tag, "_order"}, bad, 0);
    chk({tag, "_stable"}, stall_bad, 0);
    chk({tag, "_mem_we"}, we_bad, 0);
    chk({tag, "_dones"}, dones, 1);
    chk({tag, "_first_valid"}, first_valid, 2);
    chk({tag, "_done_after_last"}, done_e, last_e + 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
    if (mode == 0) begin
      chk({tag, "_last_cycle"}, last_e, NUM + 1);
      chk({tag, "_done_cycle"}, done_e, NUM + 2);
    end
  endtask

  initial begin
    int   idle_bad;
    bit   found;
    for (int i = 0; i < 1024; i++) ram[i] = DW'(i * 3);

    //          start abort rdy  busy valid idx addr
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 2};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 3};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 3};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 4};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    #13;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", m_data, 0);
    chk("rst_index", m_index, 0);
    chk("rst_we", mem_we, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start; abort = vecs[i].abort; m_ready = vecs[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_valid", i), m_valid, vecs[i].valid);
      chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("vec%0d_done", i), done, 0);
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d_index", i), m_index, vecs[i].idx);
        chk($sformatf("vec%0d_data", i), m_data, vecs[i].idx * 3);
      end
    end
    start = 1'b0; abort = 1'b0; m_ready = 1'b0;

    sweep(0, -1, "full");
    sweep(1, -1, "toggle");
    sweep(2, -1, "stall");
    sweep(0, 100, "restart_ignored");

    // abort with index 300 at the head and the sink stalled
    start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(posedge clk); #1;
      if (m_valid && m_index == AW'(300)) found = 1;
    end
    chk("abort_reach_300", found, 1);
    abort = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    chk("abort_done_late", done, 0);
    chk("abort_valid_late", m_valid, 0);
    sweep(0, -1, "after_abort");

    // asynchronous reset in the middle of a cycle at index 200
    start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(posedge clk); #1;
      if (m_valid && m_index == AW'(200)) found = 1;
    end
    chk("reset_reach_200", found, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_valid", m_valid, 0);
    chk("areset_busy", busy, 0);
    chk("areset_done", done, 0);
    chk("areset_last", m_last, 0);
    chk("areset_addr", mem_addr, 0);
    chk("areset_data", m_data, 0);
    chk("areset_index", m_index, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (busy || m_valid || done || mem_addr != '0) idle_bad++;
    end
    chk("post_reset_idle", idle_bad, 0);
    m_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alpha_stream_reader.md
Name: alpha_stream_reader

Overview:
Sequencer that reads the SVM alpha-coefficient RAM (32-bit words, 1-cycle synchronous read, 629 entries) from address 0 to NUM_SV-1. It streams each coefficient to the downstream kernel/MAC datapath over a valid/ready interface. It hides RAM read latency behind a 2-entry output buffer, so it sustains 1 word/cycle when the sink is always ready. It is the read-side counterpart of the alpha RAM load path and drives the RAM's address and write-enable pins.

Parameters:
ADDR_W, 10, RAM address width
DATA_W, 32, coefficient word width
NUM_SV, 629, number of coefficients per sweep; legal range 1..2**ADDR_W

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a sweep; honoured only in IDLE
abort  in  1  synchronous abort; returns to IDLE, discards buffered and in-flight words, no done
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse after the last word is accepted downstream
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable; constant 0
mem_rdata  in  DATA_W  RAM data_out, valid 1 cycle after mem_addr is presented
m_valid  out  1  output word valid
m_ready  in  1  sink ready
m_data  out  DATA_W  coefficient
m_index  out  ADDR_W  address the coefficient was read from
m_last  out  1  high with the word at index NUM_SV-1

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, m_valid, m_last=0. mem_addr=0, m_data=0, m_index=0. Issue counter, in-flight flag and buffer count all 0.
- Transfer: occurs when m_valid && m_ready. While m_valid=1, m_data, m_index and m_last are held stable until accepted. m_valid never drops without a transfer, except on abort or reset.
- Read issue: one RAM read per issue. mem_addr = issue counter. In-flight flag set for 1 cycle. Data is captured from mem_rdata into the buffer on the next cycle, tagged with its address.
- Credit rule: issue only when (buffer count + in_flight - pop_this_cycle) < 2. No buffer overflow is possible under any m_ready pattern.
- Buffer: 2-entry FIFO of {data, index, last}. The head drives the m_* outputs. Push and pop in the same cycle leave the count unchanged.
- State IDLE: start=1 -> RUN, issue counter=0. done=0. start while busy is ignored.
- State RUN: issue per credit rule and increment the counter. After issuing index NUM_SV-1 -> DRAIN.
- State DRAIN: no further issues. When the transfer with m_last=1 completes -> IDLE, and done=1 for exactly the following cycle.
- mem_addr holds its last issued value when not issuing. The RAM re-reads harmlessly; captures occur only on in_flight cycles.
- Latency: start at cycle 0 -> first read issued cycle 1 -> m_valid=1 at cycle 2 (index 0).
- Throughput: with m_ready held 1, one word per cycle. The last transfer occurs at cycle NUM_SV+1 and done pulses at NUM_SV+2.
- NUM_SV=1: first word has m_last=1; RUN lasts one cycle.
- abort (any state, priority over start): next cycle state=IDLE, buffer emptied, in-flight capture dropped, m_valid=0, done stays 0.
- Simultaneous abort+start in IDLE: abort wins and start is ignored.
- rst_n asserted mid-sweep: immediate return to reset values; no partial done.
- Counter width is ADDR_W+1 internally, so NUM_SV=2**ADDR_W terminates correctly without wrap.

Decomposition:
- Shared package svm_pkg: ALPHA_ADDR_W=10, ALPHA_DATA_W=32, NUM_SV=629, and the state encoding constants IDLE/RUN/DRAIN (2 bits).
- One natural sub-module, skid_fifo2: 2-entry synchronous FIFO with push/pop/count, width DATA_W+ADDR_W+1, async active-low reset.

Test Plan:
- Reset then start, m_ready=1, RAM preloaded with mem[i]=i*3 -> 629 transfers, m_data=i*3, m_index=i. m_valid first seen 2 cycles after start. m_last only at index 628; done pulse 1 cycle after it. mem_we always 0.
- m_ready toggling 1,0,0,1 repeating -> same 629-word sequence, no gaps or duplicates. Outputs stable while stalled; buffer count never exceeds 2.
- m_ready=0 for 50 cycles after start -> exactly 2 reads issued (addresses 0,1). On release, index 0 is delivered first and the stream completes normally.
- abort asserted when index 300 is at the head with m_ready=0 -> next cycle m_valid=0, busy=0, no done. A new start restarts at index 0.
- start pulsed again at index 100 during RUN -> ignored; the sweep ends at index 628 with a single done.
- rst_n pulsed low asynchronously mid-cycle at index 200 -> all outputs 0 immediately. After release, IDLE with no spontaneous activity until start.
